fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 141 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the outbound byte FIFO and serialises each byte onto TXD.
// Frame is 8N1 by default. Define UART_TX_PARITY_EN to insert an even-parity
// bit between the last data bit and the stop bit (11-bit frame).
//
// state  | meaning
// IDLE   | line high, pop a byte as soon as the FIFO is non-empty
// LOAD   | FIFO read data is valid; capture it into the shift register
// START  | start bit (low)
// DATA   | eight data bits, LSB first
// PARITY | even parity over the byte (UART_TX_PARITY_EN only)
// STOP   | stop bit (high), then back to IDLE
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Empty,
  input  logic [7:0] fifo_data_out,
  output logic       RE_fifo,
  output logic       TXD,
  output logic       busy
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_idx;
  logic [7:0]    r_shreg;
  logic          r_txd;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
`endif

  logic w_bit_end;

  assign w_bit_end = (r_timer == TLAST);
  // The pop is issued combinationally so the FIFO presents data during LOAD.
  assign RE_fifo   = (r_state == IDLE) && !Empty;
  assign busy      = (r_state != IDLE);
  assign TXD       = r_txd;

  // Frame sequencer: TXD is registered and updated one cycle ahead of each
  // state change so the line level always matches the state being entered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
      r_txd   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_txd   <= 1'b1;
          r_timer <= '0;
          if (!Empty) r_state <= LOAD;
        end
        LOAD: begin
          r_shreg <= fifo_data_out;
`ifdef UART_TX_PARITY_EN
          r_par   <= ^fifo_data_out;
`endif
          r_timer <= '0;
          r_idx   <= '0;
          r_txd   <= 1'b0;
          r_state <= START;
        end
        START: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_txd   <= r_shreg[0];
            r_state <= DATA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_shreg <= {1'b0, r_shreg[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_txd   <= r_par;
              r_state <= PARITY;
`else
              r_txd   <= 1'b1;
              r_state <= STOP;
`endif
            end else begin
              r_txd <= r_shreg[1];
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_txd   <= 1'b1;
            r_state <= STOP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
`endif
        STOP: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_timer <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx at CLKS_PER_BIT=4. A FIFO model feeds the DUT and
// a frame-level reference model predicts RE_fifo, busy and TXD every cycle.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FR = 11;
`else
  localparam int FR = 10;
`endif
  localparam int LOGN = 16384;

  logic       CLK;
  logic       RST;
  logic       Empty;
  logic [7:0] fifo_data_out;
  logic       RE_fifo;
  logic       TXD;
  logic       busy;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK),
    .RST(RST),
    .Empty(Empty),
    .fifo_data_out(fifo_data_out),
    .RE_fifo(RE_fifo),
    .TXD(TXD),
    .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  vec_t       vt[8];
  logic [7:0] q[$];
  int         re_q[$];
  logic       r_log[LOGN];
  logic       force_e;
  logic       re_s;
  logic [7:0] m_byte;
  int         m_start;
  int         m_free;
  int         cyc;
  int         n_checks;
  int         n_errors;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (j == FR - 1) return 1'b1;
    return logic'($countones(b) % 2);
  endfunction

  function automatic logic [7:0] decode(input int t);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = t + 2 + (k + 1) * CPB + CPB / 2;
      if (idx < LOGN) b[k] = r_log[idx];
    end
    return b;
  endfunction

  function automatic logic log_at(input int idx);
    if (idx >= 0 && idx < LOGN) return r_log[idx];
    return 1'bx;
  endfunction

  task automatic upd_empty();
    Empty = (q.size() == 0) || force_e;
  endtask

  task automatic push(input logic [7:0] d);
    q.push_back(d);
    upd_empty();
  endtask

  // One clock cycle: compare against the model at the falling edge, then advance.
  task automatic step();
    logic ex_busy, ex_re, ex_txd;
    @(negedge CLK);
    ex_busy = (cyc < m_free);
    ex_re   = !ex_busy && !Empty && !RST;
    ex_txd  = 1'b1;
    if (cyc >= m_start && cyc < m_start + FR * CPB)
      ex_txd = exp_bit(m_byte, (cyc - m_start) / CPB);
    chk("RE_fifo", int'(RE_fifo), int'(ex_re));
    chk("busy", int'(busy), int'(ex_busy));
    chk("TXD", int'(TXD), int'(ex_txd));
    if (ex_re) begin
      m_byte  = q[0];
      m_start = cyc + 2;
      m_free  = cyc + 2 + FR * CPB;
      re_q.push_back(cyc);
    end
    if (cyc < LOGN) r_log[cyc] = TXD;
    re_s = RE_fifo;
    @(posedge CLK);
    #1;
    cyc++;
    if (re_s && q.size() > 0) fifo_data_out = q.pop_front();
    upd_empty();
  endtask

  task automatic drain();
    int budget;
    budget = 3000;
    while ((q.size() != 0 || cyc < m_free + 1) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_pop(input int n0);
    int budget;
    budget = 200;
    while (re_q.size() == n0 && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) chk("pop_timeout", 0, 1);
  endtask

  initial begin
    int n0, t, t1, t2;
    n_checks      = 0;
    n_errors      = 0;
    cyc           = 0;
    m_start       = -100000;
    m_free        = 0;
    m_byte        = '0;
    force_e       = 1'b0;
    re_s          = 1'b0;
    RST           = 1'b1;
    Empty         = 1'b1;
    fifo_data_out = '0;
    for (int i = 0; i < LOGN; i++) r_log[i] = 1'b1;

    vt[0] = '{8'h55, 1'b0};
    vt[1] = '{8'hA3, 1'b0};
    vt[2] = '{8'h0F, 1'b0};
    vt[3] = '{8'h07, 1'b1};
    vt[4] = '{8'h03, 1'b0};
    vt[5] = '{8'hFF, 1'b0};
    vt[6] = '{8'h00, 1'b0};
    vt[7] = '{8'h80, 1'b1};

    // Reset and idle with an empty FIFO.
    repeat (5) step();
    RST = 1'b0;
    repeat (100) step();

    // Table of single frames.
    for (int i = 0; i < 8; i++) begin
      n0 = re_q.size();
      push(vt[i].data);
      drain();
      chk("single_pops", re_q.size() - n0, 1);
      if (re_q.size() > n0) begin
        t = re_q[n0];
        chk("decode_byte", int'(decode(t)), int'(vt[i].data));
        chk("start_bit", int'(log_at(t + 2 + CPB / 2)), 0);
        chk("stop_bit", int'(log_at(t + 2 + (FR - 1) * CPB + CPB / 2)), 1);
`ifdef UART_TX_PARITY_EN
        chk("parity_bit", int'(log_at(t + 2 + 9 * CPB + CPB / 2)), int'(vt[i].exp_par));
`endif
      end
      repeat (3) step();
    end

    // Back-to-back frames.
    n0 = re_q.size();
    push(8'hA3);
    push(8'h0F);
    drain();
    chk("b2b_pops", re_q.size() - n0, 2);
    if (re_q.size() >= n0 + 2) begin
      t1 = re_q[n0];
      t2 = re_q[n0 + 1];
      chk("b2b_gap", t2 - t1, FR * CPB + 2);
      chk("b2b_byte0", int'(decode(t1)), 8'hA3);
      chk("b2b_byte1", int'(decode(t2)), 8'h0F);
      chk("b2b_idle0", int'(log_at(t1 + 2 + FR * CPB)), 1);
      chk("b2b_idle1", int'(log_at(t1 + 3 + FR * CPB)), 1);
      chk("b2b_start1", int'(log_at(t1 + 4 + FR * CPB)), 0);
    end
    repeat (3) step();

    // Empty toggling during the data bits of the first frame.
    n0 = re_q.size();
    push(8'h5A);
    push(8'hC3);
    wait_pop(n0);
    t = (re_q.size() > n0) ? re_q[n0] : cyc;
    while (cyc < t + 2 + 2 * CPB) step();
    force_e = 1'b1; upd_empty();
    repeat (3) step();
    force_e = 1'b0; upd_empty();
    repeat (2) step();
    force_e = 1'b1; upd_empty();
    step();
    force_e = 1'b0; upd_empty();
    drain();
    chk("toggle_pops", re_q.size() - n0, 2);
    if (re_q.size() >= n0 + 2) begin
      chk("toggle_byte0", int'(decode(re_q[n0])), 8'h5A);
      chk("toggle_byte1", int'(decode(re_q[n0 + 1])), 8'hC3);
    end
    repeat (3) step();

    // Reset during data bit 3 of 0xFF.
    n0 = re_q.size();
    push(8'hFF);
    wait_pop(n0);
    t = (re_q.size() > n0) ? re_q[n0] : cyc;
    while (cyc < t + 2 + 4 * CPB + 1) step();
    RST = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_txd", int'(TXD), 1);
    chk("rst_re", int'(RE_fifo), 0);
    q.delete();
    upd_empty();
    m_free  = 0;
    m_start = -100000;
    repeat (3) step();
    RST = 1'b0;
    n0 = re_q.size();
    repeat (40) step();
    chk("rst_no_repop", re_q.size() - n0, 0);

    // Random bytes with random arrival spacing.
    for (int i = 0; i < 40; i++) begin
      push(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 50)) step();
    end
    drain();
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
